// File: rtl/calc_pkg.sv
// Shared definitions for the calc_exec core: opcode and FSM encodings plus
// the instruction-width helpers that size the register-select fields.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_ADD  = 2'b01,
    OP_MULT = 2'b10,
    OP_SEND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  function automatic int unsigned calc_raw(input int unsigned nreg);
    return $clog2(nreg);
  endfunction

  function automatic int unsigned calc_iw(input int unsigned nreg);
    return 2 + 3 * calc_raw(nreg);
  endfunction

endpackage

// File: rtl/calc_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DW cycles.
// o_done/o_prod/o_ovf reflect the final step so the result is usable on that edge.
module calc_mul #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_done,
  output logic [DW-1:0] o_prod,
  output logic          o_ovf
);

  localparam int unsigned CW = $clog2(DW);

  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [2*DW-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done    = r_busy && (r_cnt == CW'(DW - 1));
  assign o_prod    = w_acc_nxt[DW-1:0];
  assign o_ovf     = |w_acc_nxt[2*DW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DW{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_exec.sv
// Small register-machine core: PUSH/ADD complete on accept, MULT stalls DW
// cycles in calc_mul, SEND streams a register MSB byte first to a byte sink.
module calc_exec
  import calc_pkg::*;
#(
  parameter  int unsigned DW   = 16,
  parameter  int unsigned NREG = 4,
  parameter  int unsigned SAT  = 0,
  localparam int unsigned RAW  = calc_raw(NREG),
  localparam int unsigned IW   = calc_iw(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_vld,
  input  logic [IW-1:0] inst_wd,
  output logic          inst_rdy,
  output logic          tx_vld,
  output logic [7:0]    tx_data,
  input  logic          tx_rdy,
  output logic [DW-1:0] disp
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned BW = 2;

  state_e          r_state, w_state_nxt;
  logic [DW-1:0]   r_regs [NREG];
  logic [DW-1:0]   r_disp;
  logic [DW-1:0]   r_sbuf;
  logic [BW-1:0]   r_bcnt;
  logic [RAW-1:0]  r_rc;

  op_e             w_op;
  logic [RAW-1:0]  w_ra, w_rb, w_rc;
  logic [DW-1:0]   w_imm;
  logic [DW:0]     w_sum;
  logic [DW-1:0]   w_add_res;
  logic [DW-1:0]   w_mul_res;
  logic [DW-1:0]   w_mul_prod;
  logic            w_mul_ovf;
  logic            w_mul_done;
  logic            w_mul_start;
  logic            w_accept;

  assign w_op  = op_e'(inst_wd[IW-1 -: 2]);
  assign w_ra  = inst_wd[IW-3 -: RAW];
  assign w_rb  = inst_wd[IW-3-RAW -: RAW];
  assign w_rc  = inst_wd[IW-3-2*RAW -: RAW];
  assign w_imm = DW'(inst_wd[2*RAW-1:0]);

  assign w_accept    = inst_vld && inst_rdy;
  assign w_mul_start = w_accept && (w_op == OP_MULT);

  // One extra bit on the sum exposes the carry for saturation.
  assign w_sum     = {1'b0, r_regs[w_ra]} + {1'b0, r_regs[w_rb]};
  assign w_add_res = ((SAT != 0) && w_sum[DW]) ? '1 : w_sum[DW-1:0];
  assign w_mul_res = ((SAT != 0) && w_mul_ovf) ? '1 : w_mul_prod;

  assign tx_data = r_sbuf[DW-1 -: 8];
  assign disp    = r_disp;

  calc_mul #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (r_regs[w_ra]),
    .i_b     (r_regs[w_rb]),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod),
    .o_ovf   (w_mul_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    inst_rdy    = 1'b0;
    tx_vld      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        inst_rdy = 1'b1;
        if (inst_vld) begin
          case (w_op)
            OP_MULT: w_state_nxt = ST_MUL;
            OP_SEND: w_state_nxt = ST_SEND;
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_MUL: begin
        if (w_mul_done) w_state_nxt = ST_IDLE;
      end
      ST_SEND: begin
        tx_vld = 1'b1;
        if (tx_rdy && (r_bcnt == '0)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_disp <= '0;
      r_sbuf <= '0;
      r_bcnt <= '0;
      r_rc   <= '0;
    end else begin
      if (w_accept) begin
        case (w_op)
          OP_PUSH: begin
            r_regs[w_ra] <= w_imm;
            r_disp       <= w_imm;
          end
          OP_ADD: begin
            r_regs[w_rc] <= w_add_res;
            r_disp       <= w_add_res;
          end
          OP_MULT: r_rc <= w_rc;
          OP_SEND: begin
            r_sbuf <= r_regs[w_ra];
            r_bcnt <= BW'(NB - 1);
          end
          default: ;
        endcase
      end
      if ((r_state == ST_MUL) && w_mul_done) begin
        r_regs[r_rc] <= w_mul_res;
        r_disp       <= w_mul_res;
      end
      // Shifting out each accepted byte leaves tx_data at zero once idle.
      if ((r_state == ST_SEND) && tx_rdy) begin
        r_sbuf <= r_sbuf << 8;
        if (r_bcnt != '0) r_bcnt <= r_bcnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_exec.sv
// Directed bench for calc_exec: several parameterisations driven by
// hand-encoded instructions with hand-computed results.
`timescale 1ns/1ps
module tb_calc_exec;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // A: DW16 NREG4 SAT0
  logic        a_vld, a_rdy, a_txv, a_txr;
  logic [7:0]  a_wd, a_txd;
  logic [15:0] a_disp;
  // B/C: DW8 NREG4, SAT0 / SAT1, shared instruction stream
  logic        b_vld, b_rdy, b_txv, b_txr, c_rdy, c_txv;
  logic [7:0]  b_wd, b_txd, c_txd;
  logic [7:0]  b_disp, c_disp;
  // D: DW32 NREG4
  logic        d_vld, d_rdy, d_txv, d_txr;
  logic [7:0]  d_wd, d_txd;
  logic [31:0] d_disp;
  // E: DW16 NREG8
  logic        e_vld, e_rdy, e_txv, e_txr;
  logic [10:0] e_wd;
  logic [7:0]  e_txd;
  logic [15:0] e_disp;

  calc_exec #(.DW(16), .NREG(4), .SAT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .inst_vld(a_vld), .inst_wd(a_wd), .inst_rdy(a_rdy),
    .tx_vld(a_txv), .tx_data(a_txd), .tx_rdy(a_txr), .disp(a_disp));
  calc_exec #(.DW(8), .NREG(4), .SAT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .inst_vld(b_vld), .inst_wd(b_wd), .inst_rdy(b_rdy),
    .tx_vld(b_txv), .tx_data(b_txd), .tx_rdy(b_txr), .disp(b_disp));
  calc_exec #(.DW(8), .NREG(4), .SAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .inst_vld(b_vld), .inst_wd(b_wd), .inst_rdy(c_rdy),
    .tx_vld(c_txv), .tx_data(c_txd), .tx_rdy(b_txr), .disp(c_disp));
  calc_exec #(.DW(32), .NREG(4), .SAT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .inst_vld(d_vld), .inst_wd(d_wd), .inst_rdy(d_rdy),
    .tx_vld(d_txv), .tx_data(d_txd), .tx_rdy(d_txr), .disp(d_disp));
  calc_exec #(.DW(16), .NREG(8), .SAT(0)) u_e (
    .clk(clk), .rst_n(rst_n), .inst_vld(e_vld), .inst_wd(e_wd), .inst_rdy(e_rdy),
    .tx_vld(e_txv), .tx_data(e_txd), .tx_rdy(e_txr), .disp(e_disp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers: called at a negedge, return at the negedge after the accept edge.
  task automatic issue_a(input logic [7:0] wd);
    int unsigned n = 0;
    while (!a_rdy && n < 100) begin @(negedge clk); n++; end
    if (!a_rdy) begin total++; bad++; $display("FAIL issue_a_timeout rdy=%0b want 1", a_rdy); end
    a_vld = 1'b1; a_wd = wd;
    @(negedge clk);
    a_vld = 1'b0;
  endtask

  task automatic issue_b(input logic [7:0] wd);
    int unsigned n = 0;
    while (!(b_rdy && c_rdy) && n < 100) begin @(negedge clk); n++; end
    if (!(b_rdy && c_rdy)) begin total++; bad++; $display("FAIL issue_b_timeout rdy=%0b%0b want 11", b_rdy, c_rdy); end
    b_vld = 1'b1; b_wd = wd;
    @(negedge clk);
    b_vld = 1'b0;
  endtask

  task automatic issue_d(input logic [7:0] wd);
    int unsigned n = 0;
    while (!d_rdy && n < 100) begin @(negedge clk); n++; end
    if (!d_rdy) begin total++; bad++; $display("FAIL issue_d_timeout rdy=%0b want 1", d_rdy); end
    d_vld = 1'b1; d_wd = wd;
    @(negedge clk);
    d_vld = 1'b0;
  endtask

  task automatic issue_e(input logic [10:0] wd);
    int unsigned n = 0;
    while (!e_rdy && n < 100) begin @(negedge clk); n++; end
    if (!e_rdy) begin total++; bad++; $display("FAIL issue_e_timeout rdy=%0b want 1", e_rdy); end
    e_vld = 1'b1; e_wd = wd;
    @(negedge clk);
    e_vld = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (a_disp !== 16'h0000) begin bad++; $display("FAIL rst_disp got=%h want=0000", a_disp); end
    total++; if (a_txv !== 1'b0) begin bad++; $display("FAIL rst_txvld got=%b want=0", a_txv); end
    total++; if (a_txd !== 8'h00) begin bad++; $display("FAIL rst_txdata got=%h want=00", a_txd); end
    total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b want=1", a_rdy); end
    total++; if ({b_rdy, c_rdy, d_rdy, e_rdy} !== 4'b1111) begin bad++;
      $display("FAIL rst_rdy_all got=%b want=1111", {b_rdy, c_rdy, d_rdy, e_rdy}); end
    total++; if (d_disp !== 32'h0 || e_disp !== 16'h0 || d_txv !== 1'b0) begin bad++;
      $display("FAIL rst_other got=%h/%h/%b want=0/0/0", d_disp, e_disp, d_txv); end
    rst_n = 1'b1;
  endtask

  task automatic test_mult_send();
    int unsigned n;
    int unsigned k;
    logic [7:0] bytes [4];
    issue_a(8'h05);                      // PUSH r0=5
    issue_a(8'h13);                      // PUSH r1=3
    total++; if (a_disp !== 16'd3) begin bad++; $display("FAIL push_disp got=%0d want=3", a_disp); end
    issue_a(8'h86);                      // MULT r0,r1 -> r2
    n = 0;
    while (!a_rdy && n < 40) begin n++; @(negedge clk); end
    total++; if (n !== 16) begin bad++; $display("FAIL mult_stall got=%0d want=16", n); end
    total++; if (a_disp !== 16'd15) begin bad++; $display("FAIL mult_disp got=%0d want=15", a_disp); end
    issue_a(8'hE0);                      // SEND r2
    total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL send_rdy got=%b want=0", a_rdy); end
    k = 0;
    while (a_txv && k < 20) begin
      if (k < 4) bytes[k] = a_txd;
      k++;
      @(negedge clk);
    end
    total++; if (k !== 2) begin bad++; $display("FAIL send_count got=%0d want=2", k); end
    total++; if (bytes[0] !== 8'h00 || bytes[1] !== 8'h0F) begin bad++;
      $display("FAIL send_bytes got=%h,%h want=00,0f", bytes[0], bytes[1]); end
    total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL send_done_rdy got=%b want=1", a_rdy); end
  endtask

  task automatic test_mult_stall();
    int unsigned n = 0;
    bit early = 1'b0;
    a_vld = 1'b1; a_wd = 8'h86;          // MULT r0,r1 -> r2
    @(negedge clk);
    a_wd = 8'h39;                        // PUSH r3=9 held while stalled
    while (!a_rdy && n < 40) begin
      n++;
      if (a_disp === 16'd9) early = 1'b1;
      @(negedge clk);
    end
    total++; if (n !== 16 || early) begin bad++; $display("FAIL stall_len got=%0d early=%0b want=16 early=0", n, early); end
    total++; if (a_disp !== 16'd15) begin bad++; $display("FAIL stall_mult_disp got=%0d want=15", a_disp); end
    @(negedge clk);
    a_vld = 1'b0;
    total++; if (a_disp !== 16'd9) begin bad++; $display("FAIL stall_push got=%0d want=9", a_disp); end
  endtask

  task automatic test_add_sat();
    logic [7:0] eb [5] = '{8'd30, 8'd60, 8'd120, 8'd240, 8'hE0};
    logic [7:0] ec [5] = '{8'd30, 8'd60, 8'd120, 8'd240, 8'hFF};
    int unsigned n = 0;
    issue_b(8'h0F);                      // PUSH r0=15
    total++; if (b_disp !== 8'd15 || c_disp !== 8'd15) begin bad++;
      $display("FAIL add_push got=%0d/%0d want=15/15", b_disp, c_disp); end
    b_vld = 1'b1; b_wd = 8'h40;          // ADD r0,r0 -> r0, back to back
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (b_disp !== eb[i] || c_disp !== ec[i] || !b_rdy) begin bad++;
        $display("FAIL add_step%0d got=%h/%h rdy=%b want=%h/%h rdy=1", i, b_disp, c_disp, b_rdy, eb[i], ec[i]); end
    end
    b_vld = 1'b0;
    issue_b(8'h1F);                      // PUSH r1=15
    issue_b(8'h86);                      // MULT r0,r1 -> r2
    while (!(b_rdy && c_rdy) && n < 40) begin n++; @(negedge clk); end
    total++; if (b_disp !== 8'h20) begin bad++; $display("FAIL mult_wrap got=%h want=20", b_disp); end
    total++; if (c_disp !== 8'hFF) begin bad++; $display("FAIL mult_sat got=%h want=ff", c_disp); end
  endtask

  task automatic test_nreg8();
    int unsigned k = 0;
    logic [7:0] bytes [4];
    issue_e(11'h1EA);                    // PUSH r7=0x2A
    total++; if (e_disp !== 16'd42) begin bad++; $display("FAIL n8_disp got=%0d want=42", e_disp); end
    issue_e(11'h7C0);                    // SEND r7
    while (e_txv && k < 20) begin
      if (k < 4) bytes[k] = e_txd;
      k++;
      @(negedge clk);
    end
    total++; if (k !== 2 || bytes[0] !== 8'h00 || bytes[1] !== 8'h2A) begin bad++;
      $display("FAIL n8_send got=%0d:%h,%h want=2:00,2a", k, bytes[0], bytes[1]); end
  endtask

  task automatic test_send_wait();
    logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    bit stable;
    issue_d(8'h1F);                      // PUSH r1=15
    issue_d(8'h21);                      // PUSH r2=1
    issue_d(8'h59);                      // ADD r1,r2 -> r1 (16)
    issue_d(8'h01);                      // PUSH r0=1
    for (int dg = 2; dg <= 8; dg++) begin
      issue_d(8'h84);                    // MULT r0,r1 -> r0
      issue_d(8'h20 | 8'(dg));           // PUSH r2=dg
      issue_d(8'h48);                    // ADD r0,r2 -> r0
    end
    total++; if (d_disp !== 32'h12345678) begin bad++; $display("FAIL build_val got=%h want=12345678", d_disp); end
    issue_d(8'hC0);                      // SEND r0
    for (int k = 0; k < 4; k++) begin
      stable = 1'b1;
      for (int w = 0; w < 10; w++) begin
        if (d_txv !== 1'b1 || d_txd !== exp[k]) stable = 1'b0;
        @(negedge clk);
      end
      total++;
      if (!stable || d_txv !== 1'b1 || d_txd !== exp[k]) begin bad++;
        $display("FAIL wait_byte%0d got=%h vld=%b stable=%0b want=%h", k, d_txd, d_txv, stable, exp[k]); end
      d_txr = 1'b1;
      @(negedge clk);
      d_txr = 1'b0;
    end
    total++; if (d_txv !== 1'b0 || d_rdy !== 1'b1) begin bad++;
      $display("FAIL wait_end got vld=%b rdy=%b want vld=0 rdy=1", d_txv, d_rdy); end
  endtask

  task automatic test_reset_abort();
    int unsigned k = 0;
    logic [7:0] bytes [4];
    issue_a(8'hE0);                      // SEND r2 (holds 15)
    @(negedge clk);
    total++; if (a_txv !== 1'b1 || a_txd !== 8'h0F) begin bad++;
      $display("FAIL abort_pre got=%b/%h want=1/0f", a_txv, a_txd); end
    rst_n = 1'b0;
    #1;
    total++; if (a_txv !== 1'b0 || a_txd !== 8'h00 || a_rdy !== 1'b1) begin bad++;
      $display("FAIL abort_async got=%b/%h/%b want=0/00/1", a_txv, a_txd, a_rdy); end
    #2;
    rst_n = 1'b1;
    a_vld = 1'b1; a_wd = 8'hE0;          // SEND r2 on the first edge out of reset
    @(negedge clk);
    a_vld = 1'b0;
    total++; if (a_txv !== 1'b1 || a_disp !== 16'd0) begin bad++;
      $display("FAIL abort_first got=%b/%0d want=1/0", a_txv, a_disp); end
    while (a_txv && k < 20) begin
      if (k < 4) bytes[k] = a_txd;
      k++;
      @(negedge clk);
    end
    total++; if (k !== 2 || bytes[0] !== 8'h00 || bytes[1] !== 8'h00) begin bad++;
      $display("FAIL abort_resend got=%0d:%h,%h want=2:00,00", k, bytes[0], bytes[1]); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_vld = 1'b0; a_wd = '0; a_txr = 1'b1;
    b_vld = 1'b0; b_wd = '0; b_txr = 1'b1;
    d_vld = 1'b0; d_wd = '0; d_txr = 1'b0;
    e_vld = 1'b0; e_wd = '0; e_txr = 1'b1;
    test_reset();
    test_mult_send();
    test_mult_stall();
    test_add_sat();
    test_nreg8();
    test_send_wait();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
